coe_4x4_fetch: RTL and testbench

COE_4X4_FETCH -- requirements
Module: coe_4x4_fetch

---
 rtl/coe_4x4_fetch_pkg.sv | 33 +++
 rtl/coe_4x4_fetch_reorder.sv | 34 +++
 rtl/coe_4x4_fetch.sv | 162 ++++++++++++++++
 tb/tb_coe_4x4_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coe_4x4_fetch_pkg.sv
// Shared encodings for the 4x4 coefficient fetch block: plane types, fetch size,
// output-order modes and small index helpers.
package coe_4x4_fetch_pkg;

  localparam logic [1:0] TYPE_V  = 2'd0;
  localparam logic [1:0] TYPE_U  = 2'd1;
  localparam logic [1:0] TYPE_Y  = 2'd2;
  localparam logic [1:0] SIZE_04 = 2'd0;

  typedef enum logic [1:0] {
    MODE_RASTER  = 2'd0,
    MODE_ZQUAD   = 2'd1,
    MODE_TRANS   = 2'd2,
    MODE_RASTER3 = 2'd3
  } mode_e;

  // Plane select 3 is an alias of luma.
  function automatic logic [1:0] sel_to_type(input logic [1:0] sel);
    logic [1:0] t;
    case (sel)
      2'd1:    t = TYPE_U;
      2'd0:    t = TYPE_V;
      default: t = TYPE_Y;
    endcase
    return t;
  endfunction

  // Output position p -> raster source element when walking 2x2 quads in z-order.
  function automatic logic [3:0] zquad_src(input logic [3:0] p);
    return {p[3], p[1], p[2], p[0]};
  endfunction

endpackage

// File: rtl/coe_4x4_fetch_reorder.sv
// Combinational reordering of one raster 4x4 block (element 0 in the MSBs).
// Mode 2 transposes only when COE_FETCH_TRANSPOSE_EN is defined; otherwise it is raster.
module coe_4x4_reorder
  import coe_4x4_fetch_pkg::*;
#(
  parameter int COEFF_WIDTH = 16
) (
  input  logic [16*COEFF_WIDTH-1:0] i_blk,
  input  logic [1:0]                i_mode,
  output logic [16*COEFF_WIDTH-1:0] o_blk
);

  function automatic logic [3:0] src_idx(input logic [1:0] mode, input logic [3:0] p);
    logic [3:0] idx;
    case (mode)
      MODE_ZQUAD: idx = zquad_src(p);
`ifdef COE_FETCH_TRANSPOSE_EN
      MODE_TRANS: idx = {p[1:0], p[3:2]};
`endif
      default:    idx = p;
    endcase
    return idx;
  endfunction

  // Gather each output position from its source element.
  always_comb begin
    o_blk = '0;
    for (int p = 0; p < 16; p++) begin
      o_blk[(15-p)*COEFF_WIDTH +: COEFF_WIDTH] =
        i_blk[(15-int'(src_idx(i_mode, 4'(p))))*COEFF_WIDTH +: COEFF_WIDTH];
    end
  end

endmodule

// File: rtl/coe_4x4_fetch.sv
// Fetches a 4x4 coefficient block per request from a multi-block memory word,
// reorders it and queues it in a 2-entry output FIFO. Option: COE_FETCH_TRANSPOSE_EN.
module coe_4x4_fetch
  import coe_4x4_fetch_pkg::*;
#(
  parameter  int COEFF_WIDTH = 16,
  parameter  int XY_W        = 4,
  parameter  int ROW_BLKS    = 2,
  localparam int ADDR_W      = 2*XY_W+1,
  localparam int WORD_W      = 16*ROW_BLKS*COEFF_WIDTH,
  localparam int BLK_W       = 16*COEFF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_sel_i,
  input  logic [1:0]        req_mode_i,
  output logic              rd_ena_o,
  output logic [1:0]        rd_sel_o,
  output logic [1:0]        rd_siz_o,
  output logic [4:0]        rd_idx_o,
  output logic [XY_W-1:0]   rd_4x4_x_o,
  output logic [XY_W-1:0]   rd_4x4_y_o,
  input  logic [WORD_W-1:0] rd_dat_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BLK_W-1:0]  out_dat_o,
  output logic [XY_W-1:0]   out_x_o,
  output logic [XY_W-1:0]   out_y_o,
  output logic [1:0]        out_sel_o
);

  localparam int EW = BLK_W + 2*XY_W + 2;

  logic [XY_W-1:0] w_x;
  logic [XY_W-1:0] w_y;
  logic            w_unused_msb;
  logic            w_accept;
  logic            w_pop;
  logic [BLK_W-1:0] w_blk;
  logic [BLK_W-1:0] w_reo;
  logic [EW-1:0]   w_new;

  logic            r_rd_vld;
  logic [XY_W-1:0] r_x;
  logic [XY_W-1:0] r_y;
  logic [XY_W-1:0] r_b;
  logic [1:0]      r_sel;
  logic [1:0]      r_mode;
  logic [1:0]      r_count;
  logic [EW-1:0]   r_head;
  logic [EW-1:0]   r_tail;

  assign w_unused_msb = req_addr_i[ADDR_W-1];

  // De-interleave the z-scan address: even bits form x, odd bits form y.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < XY_W; i++) begin
      w_x[i] = req_addr_i[2*i];
      w_y[i] = req_addr_i[2*i+1];
    end
  end

  assign out_valid_o = (r_count != 2'd0);
  assign w_pop       = out_valid_o & out_ready_i;
  assign req_ready_o = (({1'b0, r_count} + {2'b00, r_rd_vld}) < 3'd2) | w_pop;
  assign w_accept    = req_valid_i & req_ready_o;

  assign rd_ena_o   = ~w_accept;
  assign rd_sel_o   = sel_to_type(req_sel_i);
  assign rd_siz_o   = SIZE_04;
  assign rd_idx_o   = 5'd0;
  assign rd_4x4_x_o = w_x;
  assign rd_4x4_y_o = w_y;

  // Capture the block tag and column slot alongside the outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_b      <= '0;
      r_sel    <= 2'd0;
      r_mode   <= 2'd0;
    end else begin
      r_rd_vld <= w_accept;
      if (w_accept) begin
        r_x    <= w_x;
        r_y    <= w_y;
        r_b    <= w_x & XY_W'(ROW_BLKS-1);
        r_sel  <= sel_to_type(req_sel_i);
        r_mode <= req_mode_i;
      end
    end
  end

  // Extract the addressed 4x4 block from the returned word (rows MSB first).
  always_comb begin
    w_blk = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_blk[(15-(r*4+c))*COEFF_WIDTH +: COEFF_WIDTH] =
          rd_dat_i[WORD_W-1-((r*4*ROW_BLKS)+4*int'(r_b)+c)*COEFF_WIDTH -: COEFF_WIDTH];
      end
    end
  end

  coe_4x4_reorder #(
    .COEFF_WIDTH(COEFF_WIDTH)
  ) u_reorder (
    .i_blk  (w_blk),
    .i_mode (r_mode),
    .o_blk  (w_reo)
  );

  assign w_new = {w_reo, r_x, r_y, r_sel};

  // Two-entry FIFO: head drives the outputs, tail holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({r_rd_vld, w_pop})
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= w_new;
          end else begin
            r_head <= w_new;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= w_new;
          end else begin
            r_tail <= w_new;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
          end
        end
        default: begin
        end
      endcase
      r_count <= r_count + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

  assign out_dat_o = r_head[EW-1 -: BLK_W];
  assign out_x_o   = r_head[2*XY_W+1 -: XY_W];
  assign out_y_o   = r_head[XY_W+1 -: XY_W];
  assign out_sel_o = r_head[1:0];

endmodule

// File: tb/tb_coe_4x4_fetch.sv
// Scoreboard bench for coe_4x4_fetch: the bench plays the memory, predicts each
// block from the word it returns, and a monitor checks blocks as they are popped.
module tb_coe_4x4_fetch;
  import coe_4x4_fetch_pkg::*;

  localparam int CW = 16;
  localparam int XY = 4;
  localparam int RB = 2;
  localparam int AW = 2*XY+1;
  localparam int WW = 16*RB*CW;
  localparam int BW = 16*CW;

  typedef struct packed {
    logic [BW-1:0] dat;
    logic [XY-1:0] x;
    logic [XY-1:0] y;
    logic [1:0]    sel;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i, req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [1:0]    req_sel_i, req_mode_i;
  logic          rd_ena_o;
  logic [1:0]    rd_sel_o, rd_siz_o;
  logic [4:0]    rd_idx_o;
  logic [XY-1:0] rd_4x4_x_o, rd_4x4_y_o;
  logic [WW-1:0] rd_dat_i;
  logic          out_valid_o, out_ready_i;
  logic [BW-1:0] out_dat_o;
  logic [XY-1:0] out_x_o, out_y_o;
  logic [1:0]    out_sel_o;

  int   checks = 0;
  int   errors = 0;
  int   n_pop  = 0;
  bit   mon_en = 0;
  bit   word_ramp = 0;
  bit   pend_v = 0;
  logic [WW-1:0] pend_w;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  coe_4x4_fetch #(.COEFF_WIDTH(CW), .XY_W(XY), .ROW_BLKS(RB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_mode_i(req_mode_i),
    .rd_ena_o(rd_ena_o), .rd_sel_o(rd_sel_o), .rd_siz_o(rd_siz_o), .rd_idx_o(rd_idx_o),
    .rd_4x4_x_o(rd_4x4_x_o), .rd_4x4_y_o(rd_4x4_y_o), .rd_dat_i(rd_dat_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_dat_o(out_dat_o),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_sel_o(out_sel_o)
  );

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [XY-1:0] dec_x(input logic [AW-1:0] a);
    logic [XY-1:0] v = '0;
    for (int i = 0; i < XY; i++) if (a[2*i]) v += XY'(1 << i);
    return v;
  endfunction

  function automatic logic [XY-1:0] dec_y(input logic [AW-1:0] a);
    logic [XY-1:0] v = '0;
    for (int i = 0; i < XY; i++) if (a[2*i+1]) v += XY'(1 << i);
    return v;
  endfunction

  function automatic logic [1:0] exp_type(input logic [1:0] s);
    if (s == 2'd1) return TYPE_U;
    else if (s == 2'd0) return TYPE_V;
    else return TYPE_Y;
  endfunction

  function automatic logic [WW-1:0] make_word();
    logic [WW-1:0] w;
    for (int k = 0; k < 16*RB; k++)
      w[WW-1-k*CW -: CW] = word_ramp ? CW'(k) : CW'($urandom);
    return w;
  endfunction

  // Reference: pick block x mod RB from the word, then order by the mode's rule.
  function automatic logic [BW-1:0] model_blk(input logic [WW-1:0] w, input int xv, input int mode);
    logic [CW-1:0] blk[16];
    logic [BW-1:0] res;
    int b, src;
    b = xv % RB;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        blk[r*4+c] = w[WW-1-(r*4*RB + 4*b + c)*CW -: CW];
    for (int p = 0; p < 16; p++) begin
      if (mode == 1) begin
        int q, k;
        q = p / 4;
        k = p % 4;
        src = ((q/2)*2 + k/2)*4 + (q%2)*2 + (k%2);
      end
`ifdef COE_FETCH_TRANSPOSE_EN
      else if (mode == 2) src = (p % 4)*4 + p/4;
`endif
      else src = p;
      res[BW-1-p*CW -: CW] = blk[src];
    end
    return res;
  endfunction

  function automatic logic [BW-1:0] pack16(input int v[16]);
    logic [BW-1:0] r;
    for (int p = 0; p < 16; p++) r[BW-1-p*CW -: CW] = CW'(v[p]);
    return r;
  endfunction

  // One clock of stimulus; on acceptance predict the block and schedule the word.
  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [1:0] s,
                       input logic [1:0] m, input logic rdy, output logic acc);
    exp_t e;
    @(posedge clk); #1;
    rd_dat_i = pend_v ? pend_w : make_word();
    pend_v = 0;
    req_valid_i = v; req_addr_i = a; req_sel_i = s; req_mode_i = m; out_ready_i = rdy;
    @(negedge clk);
    acc = v && req_ready_o;
    if (acc) begin
      chk("rd_ena_acc", BW'(rd_ena_o), BW'(0));
      chk("rd_x", BW'(rd_4x4_x_o), BW'(dec_x(a)));
      chk("rd_y", BW'(rd_4x4_y_o), BW'(dec_y(a)));
      chk("rd_sel", BW'(rd_sel_o), BW'(exp_type(s)));
      pend_w = make_word();
      pend_v = 1;
      e.dat = model_blk(pend_w, int'(dec_x(a)), int'(m));
      e.x = dec_x(a); e.y = dec_y(a); e.sel = exp_type(s);
      exp_q.push_back(e);
    end else begin
      chk("rd_ena_idle", BW'(rd_ena_o), BW'(1));
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(1'b0, '0, 2'd0, 2'd0, 1'b1, acc);
    cycle(1'b0, '0, 2'd0, 2'd0, 1'b1, acc);
    chk("drain_empty", BW'(exp_q.size()), BW'(0));
  endtask

  // Monitor: compare each popped block, and require stability while stalled.
  initial begin
    logic stall_prev = 0;
    exp_t prev, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stall_prev) begin
          chk("hold_dat", out_dat_o, prev.dat);
          chk("hold_tag", BW'({out_x_o, out_y_o, out_sel_o}), BW'({prev.x, prev.y, prev.sel}));
        end
        if (out_valid_o && out_ready_i) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got block %0h expected none", out_dat_o);
          end else begin
            e = exp_q.pop_front();
            chk("out_dat", out_dat_o, e.dat);
            chk("out_x", BW'(out_x_o), BW'(e.x));
            chk("out_y", BW'(out_y_o), BW'(e.y));
            chk("out_sel", BW'(out_sel_o), BW'(e.sel));
          end
        end
        stall_prev = out_valid_o && !out_ready_i;
        prev.dat = out_dat_o; prev.x = out_x_o; prev.y = out_y_o; prev.sel = out_sel_o;
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    logic acc;
    int   nacc, p0;
    int   z_list[16] = '{4,5,12,13,6,7,14,15,20,21,28,29,22,23,30,31};
`ifdef COE_FETCH_TRANSPOSE_EN
    int   t_list[16] = '{0,8,16,24,1,9,17,25,2,10,18,26,3,11,19,27};
`else
    int   t_list[16] = '{0,1,2,3,8,9,10,11,16,17,18,19,24,25,26,27};
`endif
    rst_n = 0; req_valid_i = 0; req_addr_i = '0; req_sel_i = 0; req_mode_i = 0;
    out_ready_i = 0; rd_dat_i = '0;
    #2;
    chk("rst_valid", BW'(out_valid_o), BW'(0));
    chk("rst_dat", out_dat_o, BW'(0));
    chk("rst_tag", BW'({out_x_o, out_y_o, out_sel_o}), BW'(0));
    chk("rst_rd_ena", BW'(rd_ena_o), BW'(1));
    repeat (2) @(negedge clk);
    rst_n = 1; mon_en = 1;

    // Address 0x0C6, luma, raster; output two cycles after the request.
    word_ramp = 1;
    cycle(1'b1, 9'h0C6, 2'd2, 2'd0, 1'b1, acc);
    chk("c6_acc", BW'(acc), BW'(1));
    chk("c6_x", BW'(rd_4x4_x_o), BW'(4'hA));
    chk("c6_siz_idx", BW'({rd_siz_o, rd_idx_o}), BW'({SIZE_04, 5'd0}));
    cycle(1'b0, '0, 2'd0, 2'd0, 1'b1, acc);
    chk("lat_p1", BW'(out_valid_o), BW'(0));
    cycle(1'b0, '0, 2'd0, 2'd0, 1'b1, acc);
    chk("lat_p2", BW'(out_valid_o), BW'(1));
    drain();

    // Z-quad order on the odd block of the ramp word.
    cycle(1'b1, 9'h001, 2'd1, 2'd1, 1'b1, acc);
    repeat (2) cycle(1'b0, '0, 2'd0, 2'd0, 1'b1, acc);
    chk("zquad_list", out_dat_o, pack16(z_list));
    drain();

    // Mode 2 on the even block of the ramp word.
    cycle(1'b1, 9'h002, 2'd0, 2'd2, 1'b1, acc);
    repeat (2) cycle(1'b0, '0, 2'd0, 2'd0, 1'b1, acc);
    chk("mode2_list", out_dat_o, pack16(t_list));
    drain();
    word_ramp = 0;

    // Back-pressure: only two requests fit, then release and drain in order.
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, AW'($urandom), 2'($urandom), 2'($urandom), 1'b0, acc);
      if (acc) nacc++;
    end
    chk("bp_accepts", BW'(nacc), BW'(2));
    chk("bp_ready_low", BW'(req_ready_o), BW'(0));
    repeat (3) cycle(1'b0, '0, 2'd0, 2'd0, 1'b0, acc);
    drain();

    // Streaming: one block per cycle with the sink always ready.
    p0 = n_pop; nacc = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, AW'(i*7 + 3), 2'($urandom), 2'($urandom), 1'b1, acc);
      if (acc) nacc++;
      if (i >= 2) chk("stream_valid", BW'(out_valid_o), BW'(1));
    end
    chk("stream_accepts", BW'(nacc), BW'(16));
    repeat (2) cycle(1'b0, '0, 2'd0, 2'd0, 1'b1, acc);
    chk("stream_pops", BW'(n_pop - p0), BW'(16));
    drain();

    // Reset with one block queued and one read outstanding.
    cycle(1'b1, AW'($urandom), 2'd2, 2'd1, 1'b0, acc);
    cycle(1'b1, AW'($urandom), 2'd1, 2'd0, 1'b0, acc);
    @(posedge clk); #1;
    req_valid_i = 0; rst_n = 0; mon_en = 0;
    #1;
    chk("rst2_valid", BW'(out_valid_o), BW'(0));
    chk("rst2_rd_ena", BW'(rd_ena_o), BW'(1));
    chk("rst2_dat", out_dat_o, BW'(0));
    exp_q.delete(); pend_v = 0;
    @(negedge clk);
    rst_n = 1; mon_en = 1;
    cycle(1'b1, 9'h0B5, 2'd3, 2'd1, 1'b1, acc);
    chk("post_rst_acc", BW'(acc), BW'(1));
    drain();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, AW'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 3) != 0, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
